// File: rtl/pingpong_tile_reader.sv
// pingpong_tile_reader: reads one ping-pong tile bank per start edge and streams it as bytes to the DWT
// Ports:
//   clk_dwt, rst (async, active low), rst_syn (sync clear, same effect as rst)
//   start                       tile-ready strobe, one event per rising edge
//   addrb_oN/enb_oN/doutb_oN    bank o1/o2 read ports; only the active bank is enabled
//   out_data/out_comp/out_last  sample, component index, last-of-component flag
//   out_valid/out_ready         sample handshake
//   busy, done, overrun         RUN/DRAIN flag, final-sample pulse, sticky start-while-busy
// Optional build macro STALL_CNT_EN adds stall_cnt[15:0] (stalled cycles in the current tile).
module pingpong_tile_reader #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 14,
    parameter int COMP_WORDS = 4096,
    parameter int NUM_COMP   = 3,
    parameter int RD_LAT     = 1
) (
    input  logic              clk_dwt,
    input  logic              rst,
    input  logic              rst_syn,
    input  logic              start,
    output logic [ADDR_W-1:0] addrb_o1,
    output logic              enb_o1,
    input  logic [16:0]       doutb_o1,
    output logic [ADDR_W-1:0] addrb_o2,
    output logic              enb_o2,
    input  logic [16:0]       doutb_o2,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_comp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              overrun
`ifdef STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);
    localparam int DEPTH = RD_LAT + 2;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int IW    = $clog2(COMP_WORDS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_COMP * COMP_WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                r_state;
    logic                  r_start_d;
    logic                  r_bank_ptr;
    logic                  r_act;
    logic [ADDR_W-1:0]     r_rd_addr;
    logic [RD_LAT-1:0]     r_vld_sr;
    logic [CW-1:0]         r_pend;
    logic [CW-1:0]         r_cnt;
    logic [PW-1:0]         r_wp;
    logic [PW-1:0]         r_rp;
    logic                  r_half;
    logic [IW-1:0]         r_ret_idx;
    logic [1:0]            r_ret_comp;
    logic [2*DATA_W-1:0]   r_mem_word [DEPTH];
    logic [1:0]            r_mem_comp [DEPTH];
    logic                  r_mem_lastc [DEPTH];
    logic                  r_mem_lastt [DEPTH];

    logic                  w_start_edge;
    logic                  w_go;
    logic                  w_bank;
    logic                  w_issue;
    logic                  w_enb;
    logic                  w_rd_vld;
    logic [16:0]           w_dout;
    logic [2*DATA_W-1:0]   w_head;
    logic                  w_xfer;
    logic                  w_pop;
    logic                  w_ret_lastc;
    logic [PW-1:0]         w_wp_nx;
    logic [PW-1:0]         w_rp_nx;
    logic                  w_unused;

    assign w_start_edge = start & ~r_start_d;
    assign w_go         = (r_state == IDLE) & w_start_edge;
    // the first read goes out on the start edge itself so its bank comes from the pointer, not r_act
    assign w_bank       = w_go ? r_bank_ptr : r_act;
    // r_pend counts FIFO words plus reads in flight, so a FIFO slot is reserved for every issued read
    assign w_issue      = (w_go | (r_state == RUN)) & (r_pend < CW'(DEPTH));
    assign w_enb        = enb_o1 | enb_o2;
    assign w_rd_vld     = r_vld_sr[RD_LAT-1];
    assign w_dout       = r_act ? doutb_o2 : doutb_o1;
    assign w_unused     = doutb_o1[16] ^ doutb_o2[16];
    assign w_head       = r_mem_word[r_rp];
    assign w_ret_lastc  = r_ret_idx == IW'(COMP_WORDS - 1);
    assign w_wp_nx      = (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + PW'(1);
    assign w_rp_nx      = (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + PW'(1);

    // the FIFO head is the serializer: r_half selects the low then the high byte of the head word
    assign out_valid    = r_cnt != '0;
    assign out_data     = out_valid ? (r_half ? w_head[2*DATA_W-1:DATA_W] : w_head[DATA_W-1:0]) : '0;
    assign out_comp     = out_valid ? r_mem_comp[r_rp] : 2'd0;
    assign out_last     = out_valid & r_half & r_mem_lastc[r_rp];
    assign w_xfer       = out_valid & out_ready;
    assign w_pop        = w_xfer & r_half;
    assign done         = w_pop & r_mem_lastt[r_rp] & ~rst_syn;
    assign busy         = r_state != IDLE;

    always_ff @(posedge clk_dwt or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_start_d  <= 1'b0;
            r_bank_ptr <= 1'b0;
            r_act      <= 1'b0;
            r_rd_addr  <= '0;
            overrun    <= 1'b0;
            enb_o1     <= 1'b0;
            enb_o2     <= 1'b0;
            addrb_o1   <= '0;
            addrb_o2   <= '0;
        end else if (rst_syn) begin
            r_state    <= IDLE;
            r_start_d  <= 1'b0;
            r_bank_ptr <= 1'b0;
            r_act      <= 1'b0;
            r_rd_addr  <= '0;
            overrun    <= 1'b0;
            enb_o1     <= 1'b0;
            enb_o2     <= 1'b0;
            addrb_o1   <= '0;
            addrb_o2   <= '0;
        end else begin
            r_start_d <= start;
            if (w_start_edge & busy)
                overrun <= 1'b1;
            enb_o1   <= w_issue & ~w_bank;
            enb_o2   <= w_issue & w_bank;
            addrb_o1 <= (w_issue & ~w_bank) ? r_rd_addr : '0;
            addrb_o2 <= (w_issue & w_bank) ? r_rd_addr : '0;
            if (w_go) begin
                r_act      <= r_bank_ptr;
                r_bank_ptr <= ~r_bank_ptr;
            end
            if (w_issue)
                r_rd_addr <= (r_rd_addr == LAST_ADDR) ? '0 : r_rd_addr + ADDR_W'(1);
            r_state <= w_go ? RUN :
                       (r_state == RUN && w_issue && r_rd_addr == LAST_ADDR) ? DRAIN :
                       (r_state == DRAIN && done) ? IDLE : r_state;
        end
    end

    always_ff @(posedge clk_dwt or negedge rst) begin
        if (!rst) begin
            r_vld_sr   <= '0;
            r_pend     <= '0;
            r_cnt      <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_half     <= 1'b0;
            r_ret_idx  <= '0;
            r_ret_comp <= 2'd0;
        end else if (rst_syn) begin
            r_vld_sr   <= '0;
            r_pend     <= '0;
            r_cnt      <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_half     <= 1'b0;
            r_ret_idx  <= '0;
            r_ret_comp <= 2'd0;
        end else begin
            // bit 0 mirrors the registered enable; the top bit marks data present on doutb
            r_vld_sr <= RD_LAT'({r_vld_sr, w_enb});
            r_pend   <= r_pend + CW'(w_issue) - CW'(w_pop);
            r_cnt    <= r_cnt + CW'(w_rd_vld) - CW'(w_pop);
            if (w_rd_vld)
                r_wp <= w_wp_nx;
            if (w_pop)
                r_rp <= w_rp_nx;
            if (w_xfer)
                r_half <= ~r_half;
            // returned words are tagged in issue order, so a word counter gives component and last flags
            if (w_go) begin
                r_ret_idx  <= '0;
                r_ret_comp <= 2'd0;
            end else if (w_rd_vld) begin
                r_ret_idx  <= w_ret_lastc ? '0 : r_ret_idx + IW'(1);
                r_ret_comp <= w_ret_lastc ? r_ret_comp + 2'd1 : r_ret_comp;
            end
        end
    end

    always_ff @(posedge clk_dwt) begin
        if (w_rd_vld) begin
            r_mem_word[r_wp]  <= w_dout[2*DATA_W-1:0];
            r_mem_comp[r_wp]  <= r_ret_comp;
            r_mem_lastc[r_wp] <= w_ret_lastc;
            r_mem_lastt[r_wp] <= w_ret_lastc & (r_ret_comp == 2'(NUM_COMP - 1));
        end
    end

`ifdef STALL_CNT_EN
    always_ff @(posedge clk_dwt or negedge rst) begin
        if (!rst)
            stall_cnt <= 16'd0;
        else if (rst_syn || w_go)
            stall_cnt <= 16'd0;
        else if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pingpong_tile_reader.sv
// tb_pingpong_tile_reader: directed bench for pingpong_tile_reader with a small component size
module tb_pingpong_tile_reader;
    localparam int CW    = 512;
    localparam int NC    = 3;
    localparam int TOT   = 2 * NC * CW;
    localparam int DEPTH = 3;

    logic        clk_dwt = 1'b0;
    logic        rst = 1'b0;
    logic        rst_syn = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic [13:0] addrb_o1, addrb_o2;
    logic        enb_o1, enb_o2;
    logic [16:0] doutb_o1 = '0, doutb_o2 = '0;
    logic [7:0]  out_data;
    logic [1:0]  out_comp;
    logic        out_valid, out_last, busy, done, overrun;
`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif
    int          vectors = 0;
    int          errors = 0;
    logic        exp_ovr = 1'b0;

    always #5 clk_dwt = ~clk_dwt;

    pingpong_tile_reader #(.COMP_WORDS(CW)) dut (
        .clk_dwt(clk_dwt), .rst(rst), .rst_syn(rst_syn), .start(start),
        .addrb_o1(addrb_o1), .enb_o1(enb_o1), .doutb_o1(doutb_o1),
        .addrb_o2(addrb_o2), .enb_o2(enb_o2), .doutb_o2(doutb_o2),
        .out_data(out_data), .out_comp(out_comp), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done),
        .overrun(overrun)
`ifdef STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    function automatic logic [16:0] word_of(input logic bank, input logic [13:0] a);
        return bank ? {1'b1, a[7:0] ^ 8'hC3, a[13:6]} : {1'b1, a[7:0] ^ 8'h5A, a[7:0]};
    endfunction

    always @(posedge clk_dwt) begin
        if (enb_o1) doutb_o1 <= word_of(1'b0, addrb_o1);
        if (enb_o2) doutb_o2 <= word_of(1'b1, addrb_o2);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_tile(input logic bank, input bit rnd, input int stall_at, input int stall_len,
                            input int ovr_at, input int abort_at, input int exp_stall);
        int n, cyc, issued, words, dones, stall_left;
        bit stalled_once, ovr_sent, xfer;
        logic [13:0] a;
        logic [16:0] w;
        logic [7:0] eb;
        n = 0; cyc = 0; issued = 0; words = 0; dones = 0; stall_left = 0;
        stalled_once = 0; ovr_sent = 0;
        start = 1'b1;
        while (n < TOT) begin
            @(posedge clk_dwt);
            cyc++;
            #1;
            start = (cyc == 1) || (cyc > 2 && n == ovr_at && !ovr_sent);
            if (cyc > 2 && start) begin
                ovr_sent = 1;
                exp_ovr = 1'b1;
            end
            if (n == stall_at && !stalled_once) begin
                stalled_once = 1;
                stall_left = stall_len;
            end
            out_ready = (stall_left > 0) ? 1'b0 : rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall_left > 0) stall_left--;
            rst_syn = (n == abort_at);
            #1;
            if (cyc <= 3) chk("first_valid_latency", out_valid, cyc == 3);
`ifdef STALL_CNT_EN
            if (cyc == 2) chk("stall_cnt_clear", stall_cnt, 0);
`endif
            chk("idle_bank_quiet", bank ? {enb_o1, addrb_o1} : {enb_o2, addrb_o2}, 0);
            if (bank ? enb_o2 : enb_o1) begin
                chk("rd_addr", bank ? addrb_o2 : addrb_o1, issued);
                issued++;
            end
            chk("fifo_bound", (issued - words) <= DEPTH, 1);
            xfer = out_valid && out_ready;
            if (out_valid) begin
                a = 14'(n / 2);
                w = word_of(bank, a);
                eb = n[0] ? w[15:8] : w[7:0];
                chk("sample", {out_data, out_comp, out_last, done},
                    {eb, 2'(a / CW), (n % (2 * CW)) == 2 * CW - 1, xfer && n == TOT - 1 && !rst_syn});
            end else
                chk("done_idle", done, 0);
            if (done) dones++;
            if (xfer) begin
                if (n[0]) words++;
                n++;
            end
            if (rst_syn) begin
                @(posedge clk_dwt);
                #1 rst_syn = 1'b0;
                #1 chk("abort_state", {out_valid, busy, enb_o1, enb_o2, done, overrun}, 0);
                exp_ovr = 1'b0;
                return;
            end
            if (cyc > 20000) begin
                chk("tile_timeout", n, TOT);
                break;
            end
        end
        @(posedge clk_dwt);
        #2;
        chk("done_count", dones, 1);
        chk("post_tile_idle", {busy, out_valid, enb_o1, enb_o2}, 0);
        chk("overrun", overrun, exp_ovr);
`ifdef STALL_CNT_EN
        if (exp_stall >= 0) chk("stall_cnt_at_done", stall_cnt, exp_stall);
`endif
    endtask

    initial begin
        repeat (3) @(posedge clk_dwt);
        #2 chk("reset_state", {out_valid, busy, done, overrun, enb_o1, enb_o2, addrb_o1, addrb_o2,
                               out_data, out_comp, out_last}, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk_dwt);
        #2;
        run_tile(1'b0, 1'b0, -1, 0, -1, -1, 0);
        run_tile(1'b1, 1'b0, -1, 0, -1, -1, 0);
        run_tile(1'b0, 1'b1, 700, 100, -1, -1, -1);
        run_tile(1'b1, 1'b0, -1, 0, 625, -1, 0);
        run_tile(1'b0, 1'b0, -1, 0, -1, 1250, -1);
        run_tile(1'b0, 1'b0, 300, 37, -1, -1, 37);
        run_tile(1'b1, 1'b0, -1, 0, -1, 10, -1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
